sar_logic: RTL and testbench
============================

# sar_logic

Synchronous successive-approximation controller for the SAR ADC, directly downstream of the clocked sense amplifier. It sequences track/hold sampling, drives the capacitive-DAC trial code and the comparator clock, consumes the comparator's `dout`/`doutb` decision each bit, and delivers the N-bit result with a one-cycle valid strobe. Pure digital, with no pwl ports; it pairs with the mLingua comparator and DAC models in the ADC top level.

## Interface
- `N`, default 8, resolution in bits (≥2).
- `NSAMP`, default 2, number of track (sample) cycles per conversion (≥1).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `start`  in  1  conversion request; level-sampled only in IDLE.
- `dout`  in  1  comparator positive decision (1 ⇒ vinp > vinn, i.e. input > DAC).
- `doutb`  in  1  comparator complementary decision.
- `sample`  out  1  track/hold control; 1 = track.
- `cmp_clk`  out  1  comparator clock; its rising edge fires regeneration.
- `dac_code`  out  N  DAC trial code.
- `code`  out  N  final conversion result.
- `valid`  out  1  one-cycle strobe; `code` and `err` are valid.
- `busy`  out  1  conversion in progress.
- `err`  out  1  at least one undecided comparison occurred in the last conversion.

## Operation
- All outputs are registered. Reset values, with `rstn` low at a clk edge: `sample`=0, `cmp_clk`=0, `dac_code`=0, `code`=0, `valid`=0, `busy`=0, `err`=0, state=IDLE, bit index=N-1, internal result=0.
- States:
  - IDLE: `start`=1 → SAMPLE; `busy`=1, `sample`=1, `dac_code`=0, `err`=0, result=0, sample counter=0.
  - SAMPLE: holds for NSAMP cycles. On the last one → SETTLE(bit N-1); `sample`=0, `dac_code`=1<<(N-1).
  - SETTLE(i): `cmp_clk`=0, and DAC settles. Next edge → EVAL(i); `cmp_clk`=1.
  - EVAL(i): at the next edge, capture the decision and set `cmp_clk`=0.
    - `dout`=1 & `doutb`=0 → dec=1.
    - `dout`=0 & `doutb`=1 → dec=0.
    - `dout`==`doutb` (undecided/metastable) → dec=0 and set `err`=1; `err` is sticky within the conversion.
    - result[i]=dec.
    - If i>0 → SETTLE(i-1), with `dac_code` = result bits N-1..i (new), bit i-1 = 1, lower bits 0.
    - If i=0 → IDLE; `code`=final result, `dac_code`=final result, `valid`=1, `busy`=0.
- `valid` returns to 0 on the following edge. `code` and `err` hold until the next conversion completes or reset; `err` clears at the next start.
- `start` is ignored whenever state≠IDLE, including the edge on which `valid` asserts.
- Reset mid-conversion: at the first edge with `rstn`=0, all outputs take reset values, no `valid` pulse is issued, and the partial result is discarded.

## Timing
- Edge E0: `start` seen in IDLE.
- Track window: `sample`=1 for edges E0..E0+NSAMP-1, i.e. NSAMP cycles.
- Bit i=N-1-k:
  - SETTLE starts at E0+NSAMP+2k.
  - `cmp_clk` is high from E0+NSAMP+2k+1 to E0+NSAMP+2k+2.
  - The decision is sampled at E0+NSAMP+2k+2.
- Comparator timing budget:
  - Comparator resolve time (aperture + regeneration) must be < 1 clk period.
  - The DAC has 1 full period (SETTLE) before each `cmp_clk` rise.
- `valid`=1 on the cycle after edge E0+NSAMP+2N. Default latency is 18 cycles.
- Minimum start-to-start period is NSAMP+2N+1 = 19 cycles at default.

## Test plan
- Reset: hold `rstn`=0 for 3 cycles with `start`=1 → every output at its reset value; release → conversion begins at the first edge with `rstn`=1.
- Ideal comparator model (`dout` = input ≥ `dac_code`, `doutb`=~`dout`) with input 0xA5 → `dac_code` sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5; `code`=0xA5, `err`=0, `valid` pulse 18 cycles after start.
- Extremes: `dout`=1/`doutb`=0 always → `code`=0xFF; `dout`=0/`doutb`=1 always → `code`=0x00; `cmp_clk` shows exactly 8 pulses each.
- Undecided bit: input 0xFF but `dout`=`doutb`=1 during EVAL of bit 3 → `code`=0xF7, `err`=1; next conversion with clean decisions → `err`=0.
- Protocol: `start` held high continuously → conversions every 19 cycles, exactly one `valid` each; a `start` pulse mid-conversion → ignored, no extra conversion.
- Reset mid-conversion at cycle 7 → outputs reset immediately, no `valid`; next start produces the correct code.

Source files
------------

// File: rtl/sar_logic_if.sv
// Signal bundle between the SAR controller and its surroundings: conversion
// handshake, comparator decision inputs and DAC/track-hold drive outputs.
`timescale 1ns/1ps
interface sar_logic_if #(
    parameter int N = 8
);
    logic         start;
    logic         dout;
    logic         doutb;
    logic         sample;
    logic         cmp_clk;
    logic [N-1:0] dac_code;
    logic [N-1:0] code;
    logic         valid;
    logic         busy;
    logic         err;

    // Requester/comparator side: issues start, returns decisions, observes results
    modport master (
        output start, dout, doutb,
        input  sample, cmp_clk, dac_code, code, valid, busy, err
    );

    // Controller side
    modport slave (
        input  start, dout, doutb,
        output sample, cmp_clk, dac_code, code, valid, busy, err
    );
endinterface

// File: rtl/sar_logic.sv
// Synchronous successive-approximation controller: track/hold sequencing, DAC
// trial codes, comparator clocking and N-bit result delivery with a valid strobe.
`timescale 1ns/1ps
module sar_logic #(
    parameter int N     = 8,
    parameter int NSAMP = 2
) (
    input  logic        clk,
    input  logic        rstn,
    sar_logic_if.slave  bus
);
    localparam int IW = $clog2(N);
    localparam int CW = (NSAMP > 1) ? $clog2(NSAMP) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SAMPLE = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_EVAL   = 2'd3;

    localparam logic [IW-1:0] TOP_BIT  = IW'(N - 1);
    localparam logic [IW-1:0] BIT_ONE  = IW'(1);
    localparam logic [CW-1:0] SAMP_END = CW'(NSAMP - 1);
    localparam logic [N-1:0]  LSB_ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]  MSB_ONE  = {1'b1, {(N-1){1'b0}}};

    logic [1:0]    state_r;
    logic [IW-1:0] bit_r;
    logic [CW-1:0] samp_cnt_r;
    logic [N-1:0]  result_r;
    logic          sample_r;
    logic          cmp_clk_r;
    logic [N-1:0]  dac_code_r;
    logic [N-1:0]  code_r;
    logic          valid_r;
    logic          busy_r;
    logic          err_r;

    logic          dec_s;
    logic          undecided_s;
    logic [N-1:0]  result_upd_s;
    logic [N-1:0]  trial_s;

    // Comparator decision and the next trial code; equal dout/doutb resolves to 0
    always_comb begin
        undecided_s           = (bus.dout == bus.doutb);
        dec_s                 = bus.dout & ~bus.doutb;
        result_upd_s          = result_r;
        result_upd_s[bit_r]   = dec_s;
        if (bit_r != {IW{1'b0}}) begin
            trial_s = result_upd_s | (LSB_ONE << (bit_r - BIT_ONE));
        end else begin
            trial_s = result_upd_s;
        end
    end

    // Conversion sequencer and registered outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            bit_r      <= TOP_BIT;
            samp_cnt_r <= {CW{1'b0}};
            result_r   <= {N{1'b0}};
            sample_r   <= 1'b0;
            cmp_clk_r  <= 1'b0;
            dac_code_r <= {N{1'b0}};
            code_r     <= {N{1'b0}};
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_r    <= ST_SAMPLE;
                        busy_r     <= 1'b1;
                        sample_r   <= 1'b1;
                        dac_code_r <= {N{1'b0}};
                        err_r      <= 1'b0;
                        result_r   <= {N{1'b0}};
                        samp_cnt_r <= {CW{1'b0}};
                        bit_r      <= TOP_BIT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SAMPLE: begin
                    if (samp_cnt_r == SAMP_END) begin
                        state_r    <= ST_SETTLE;
                        sample_r   <= 1'b0;
                        dac_code_r <= MSB_ONE;
                        bit_r      <= TOP_BIT;
                    end else begin
                        samp_cnt_r <= samp_cnt_r + CW'(1);
                    end
                end
                ST_SETTLE: begin
                    state_r   <= ST_EVAL;
                    cmp_clk_r <= 1'b1;
                end
                ST_EVAL: begin
                    cmp_clk_r <= 1'b0;
                    result_r  <= result_upd_s;
                    if (undecided_s) begin
                        err_r <= 1'b1;
                    end else begin
                        err_r <= err_r;
                    end
                    // Last bit hands the finished word to both code and the DAC
                    if (bit_r == {IW{1'b0}}) begin
                        state_r    <= ST_IDLE;
                        code_r     <= result_upd_s;
                        dac_code_r <= result_upd_s;
                        valid_r    <= 1'b1;
                        busy_r     <= 1'b0;
                    end else begin
                        state_r    <= ST_SETTLE;
                        dac_code_r <= trial_s;
                        bit_r      <= bit_r - BIT_ONE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    sample_r  <= 1'b0;
                    cmp_clk_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sample   = sample_r;
    assign bus.cmp_clk  = cmp_clk_r;
    assign bus.dac_code = dac_code_r;
    assign bus.code     = code_r;
    assign bus.valid    = valid_r;
    assign bus.busy     = busy_r;
    assign bus.err      = err_r;
endmodule

// File: tb/tb_sar_logic.sv
// Self-checking bench for sar_logic: comparator model plus a binary-search
// reference that predicts trial codes, result, err flag and latency.
`timescale 1ns/1ps
module tb_sar_logic;
    localparam int N     = 8;
    localparam int NSAMP = 2;
    localparam int LAT   = NSAMP + 2 * N;
    localparam int PER   = NSAMP + 2 * N + 1;

    logic       clk;
    logic       rstn;
    logic [7:0] vin;
    int         mode;   // 0 ideal, 1 always high, 2 always low, 3 undecided on bit 3
    int         total;
    int         bad;
    logic       d_s;
    logic       db_s;

    sar_logic_if #(.N(N)) bus ();

    sar_logic #(.N(N), .NSAMP(NSAMP)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparator model; the bit under test is the lowest set bit of the trial code
    always_comb begin
        d_s  = (vin >= bus.dac_code);
        db_s = ~d_s;
        case (mode)
            1: begin d_s = 1'b1; db_s = 1'b0; end
            2: begin d_s = 1'b0; db_s = 1'b1; end
            3: begin
                if (bus.dac_code[3] && (bus.dac_code[2:0] == 3'd0)) begin
                    d_s = 1'b1; db_s = 1'b1;
                end else begin
                    d_s = d_s; db_s = db_s;
                end
            end
            default: begin d_s = d_s; db_s = db_s; end
        endcase
    end
    assign bus.dout  = d_s;
    assign bus.doutb = db_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_sample"},  {31'd0, bus.sample},  32'd0);
        chk({tag, "_cmp_clk"}, {31'd0, bus.cmp_clk}, 32'd0);
        chk({tag, "_dac"},     {24'd0, bus.dac_code}, 32'd0);
        chk({tag, "_code"},    {24'd0, bus.code},    32'd0);
        chk({tag, "_valid"},   {31'd0, bus.valid},   32'd0);
        chk({tag, "_busy"},    {31'd0, bus.busy},    32'd0);
        chk({tag, "_err"},     {31'd0, bus.err},     32'd0);
    endtask

    // Reference: plain binary search, MSB first
    task automatic model(input logic [7:0] v, input int m, output logic [7:0] c,
                         output logic e, output logic [7:0] trials [8]);
        logic [7:0] t;
        logic       d;
        c = 8'd0;
        e = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            t = c | (8'd1 << i);
            trials[7 - i] = t;
            if (m == 1) d = 1'b1;
            else if (m == 2) d = 1'b0;
            else if (m == 3 && i == 3) begin d = 1'b0; e = 1'b1; end
            else d = (v >= t);
            if (d) c = c | (8'd1 << i);
        end
    endtask

    // One full conversion; caller is #1 after an edge with the DUT idle
    task automatic convert(input logic [7:0] v, input int m, input string tag);
        logic [7:0] exp_code;
        logic       exp_err;
        logic [7:0] exp_tr [8];
        logic [7:0] seen [$];
        int         samp_cnt;
        int         lat;
        logic       prev_cmp;
        vin  = v;
        mode = m;
        model(v, m, exp_code, exp_err, exp_tr);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({tag, "_busy_e0"},   {31'd0, bus.busy},   32'd1);
        chk({tag, "_sample_e0"}, {31'd0, bus.sample}, 32'd1);
        samp_cnt = 1;
        lat      = -1;
        prev_cmp = 1'b0;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (bus.sample) samp_cnt++;
            if (bus.cmp_clk && !prev_cmp) seen.push_back(bus.dac_code);
            prev_cmp = bus.cmp_clk;
            if (bus.valid) lat = k;
        end
        chk({tag, "_latency"},  lat, LAT);
        chk({tag, "_code"},     {24'd0, bus.code},     {24'd0, exp_code});
        chk({tag, "_err"},      {31'd0, bus.err},      {31'd0, exp_err});
        chk({tag, "_dac_fin"},  {24'd0, bus.dac_code}, {24'd0, exp_code});
        chk({tag, "_busy_fin"}, {31'd0, bus.busy},     32'd0);
        chk({tag, "_track"},    samp_cnt, NSAMP);
        chk({tag, "_pulses"},   seen.size(), N);
        for (int j = 0; j < N && j < seen.size(); j++)
            chk({tag, "_trial"}, {24'd0, seen[j]}, {24'd0, exp_tr[j]});
        @(posedge clk); #1;
        chk({tag, "_valid_drop"}, {31'd0, bus.valid}, 32'd0);
        chk({tag, "_code_hold"},  {24'd0, bus.code},  {24'd0, exp_code});
    endtask

    initial begin
        int         vcount;
        int         vpos [$];
        logic [7:0] r;
        total     = 0;
        bad       = 0;
        vin       = 8'd0;
        mode      = 0;
        rstn      = 1'b0;
        bus.start = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk_reset("reset");
        end
        rstn = 1'b1;
        convert(8'h5A, 0, "post_reset");

        convert(8'hA5, 0, "ideal_a5");
        convert(8'($urandom), 1, "all_high");
        convert(8'($urandom), 2, "all_low");
        convert(8'hFF, 3, "undecided");
        convert(8'($urandom), 0, "clean_after_err");
        convert(8'h00, 0, "in_zero");
        convert(8'hFF, 0, "in_full");
        for (int i = 0; i < 4; i++) convert(8'($urandom), 0, "random");

        // start held high: back-to-back conversions, one valid each
        r         = 8'($urandom);
        vin       = r;
        mode      = 0;
        bus.start = 1'b1;
        for (int k = 1; k <= 3 * PER; k++) begin
            @(posedge clk); #1;
            if (bus.valid) begin
                vpos.push_back(k);
                chk("cont_code", {24'd0, bus.code}, {24'd0, r});
            end
        end
        bus.start = 1'b0;
        chk("cont_count", vpos.size(), 3);
        for (int j = 1; j < vpos.size(); j++)
            chk("cont_period", vpos[j] - vpos[j-1], PER);
        repeat (PER) @(posedge clk);
        #1;

        // start pulse in the middle of a conversion is ignored
        r         = 8'($urandom);
        vin       = r;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        vcount = 0;
        for (int k = 7; k <= 45; k++) begin
            @(posedge clk); #1;
            if (bus.valid) begin
                vcount++;
                chk("pulse_lat",  k, LAT);
                chk("pulse_code", {24'd0, bus.code}, {24'd0, r});
            end
        end
        chk("pulse_count", vcount, 1);

        // reset at cycle 7 of a conversion
        vin       = 8'($urandom);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        chk_reset("mid_reset");
        rstn   = 1'b1;
        vcount = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (bus.valid) vcount++;
        end
        chk("mid_reset_novalid", vcount, 0);
        convert(8'($urandom), 0, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
